// File: rtl/datapath_pkg.sv
// Shared defaults and encodings for the datapath register file blocks.
package datapath_pkg;

  localparam int unsigned DEF_DATA_W = 32;
  localparam int unsigned DEF_DEPTH  = 32;
  localparam int unsigned ZERO_IDX   = 0;

  typedef enum logic {
    ST_INIT,
    ST_RUN
  } rf_state_e;

endpackage

// File: rtl/regfile_read_port.sv
// One combinational read port: zero/range masking, write-first bypass and busy masking.
module regfile_read_port
  import datapath_pkg::*;
#(
  parameter int unsigned DATA_W   = DEF_DATA_W,
  parameter int unsigned DEPTH    = DEF_DEPTH,
  parameter int unsigned ZERO_REG = 1,
  parameter int unsigned ADDR_W   = $clog2(DEPTH)
) (
  input  logic              ready,
  input  logic [ADDR_W-1:0] rd_addr,
  input  logic [DATA_W-1:0] entry_data,
  input  logic              entry_busy,
  input  logic              wr_qual,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_busy
);

  logic masked;
  logic bypass;

  assign masked = !ready
                || ((ZERO_REG != 0) && (rd_addr == ADDR_W'(ZERO_IDX)))
                || (32'(rd_addr) >= DEPTH);
  assign bypass = wr_qual && (wr_addr == rd_addr);

  always_comb begin
    rd_data = '0;
    rd_busy = 1'b0;
    if (!masked) begin
      if (bypass) begin
        rd_data = wr_data;
      end else begin
        rd_data = entry_data;
        rd_busy = entry_busy;
      end
    end
  end

endmodule

// File: rtl/regfile_scoreboard.sv
// Register file with post-reset clear sweep, write-first bypass and a per-entry
// pending-write scoreboard for RAW hazard detection in decode.
module regfile_scoreboard
  import datapath_pkg::*;
#(
  parameter int unsigned DATA_W   = DEF_DATA_W,
  parameter int unsigned DEPTH    = DEF_DEPTH,
  parameter int unsigned NUM_RD   = 2,
  parameter int unsigned ZERO_REG = 1,
  localparam int unsigned ADDR_W  = $clog2(DEPTH)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
  output logic [NUM_RD*DATA_W-1:0] rd_data,
  output logic [NUM_RD-1:0]        rd_busy,
  input  logic                     wr_en,
  input  logic [ADDR_W-1:0]        wr_addr,
  input  logic [DATA_W-1:0]        wr_data,
  input  logic                     rsv_en,
  input  logic [ADDR_W-1:0]        rsv_addr,
  output logic                     ready
);

  rf_state_e         state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic [DEPTH-1:0]  busy_q, busy_d;
  logic [DATA_W-1:0] mem_q [DEPTH];

  logic sweep_we;
  logic sweep_done;
  logic wr_qual;
  logic rsv_qual;

  assign sweep_done = (cnt_q == ADDR_W'(DEPTH - 1));

  assign wr_qual  = ready && wr_en && (32'(wr_addr) < DEPTH)
                 && !((ZERO_REG != 0) && (wr_addr == ADDR_W'(ZERO_IDX)));
  assign rsv_qual = ready && rsv_en && (32'(rsv_addr) < DEPTH)
                 && !((ZERO_REG != 0) && (rsv_addr == ADDR_W'(ZERO_IDX)));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_INIT;
      cnt_q   <= '0;
      busy_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_INIT: if (sweep_done) state_d = ST_RUN;
      ST_RUN:  state_d = ST_RUN;
      default: state_d = ST_INIT;
    endcase
  end

  always_comb begin
    ready    = (state_q == ST_RUN);
    sweep_we = (state_q == ST_INIT);
  end

  assign cnt_d = sweep_we ? cnt_q + ADDR_W'(1) : cnt_q;

  // Reservation is applied last so a same-cycle newer producer keeps the bit set.
  always_comb begin
    busy_d = busy_q;
    if (wr_qual)  busy_d[wr_addr]  = 1'b0;
    if (rsv_qual) busy_d[rsv_addr] = 1'b1;
  end

  // Storage has no reset of its own; the INIT sweep clears it.
  always_ff @(posedge clk) begin
    if (sweep_we) begin
      mem_q[cnt_q] <= '0;
    end else if (wr_qual) begin
      mem_q[wr_addr] <= wr_data;
    end
  end

  for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
    logic [ADDR_W-1:0] addr;
    assign addr = rd_addr[i*ADDR_W +: ADDR_W];

    regfile_read_port #(
      .DATA_W   (DATA_W),
      .DEPTH    (DEPTH),
      .ZERO_REG (ZERO_REG),
      .ADDR_W   (ADDR_W)
    ) u_port (
      .ready      (ready),
      .rd_addr    (addr),
      .entry_data (mem_q[addr]),
      .entry_busy (busy_q[addr]),
      .wr_qual    (wr_qual),
      .wr_addr    (wr_addr),
      .wr_data    (wr_data),
      .rd_data    (rd_data[i*DATA_W +: DATA_W]),
      .rd_busy    (rd_busy[i])
    );
  end

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Bench for regfile_scoreboard: directed scenarios plus random traffic against
// an array-based reference model.
module tb_regfile_scoreboard;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned DEPTH  = 32;
  localparam int unsigned NUM_RD = 2;
  localparam int unsigned ADDR_W = 5;

  logic                     clk = 1'b0;
  logic                     rst;
  logic [NUM_RD*ADDR_W-1:0] rd_addr;
  logic [NUM_RD*DATA_W-1:0] rd_data;
  logic [NUM_RD-1:0]        rd_busy;
  logic                     wr_en;
  logic [ADDR_W-1:0]        wr_addr;
  logic [DATA_W-1:0]        wr_data;
  logic                     rsv_en;
  logic [ADDR_W-1:0]        rsv_addr;
  logic                     ready;

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;

  // Reference model: architectural contents, pending flags, sweep progress.
  logic [DATA_W-1:0] m_mem  [DEPTH];
  bit                m_busy [DEPTH];
  bit                m_ready;
  int                m_sweep;

  regfile_scoreboard #(
    .DATA_W   (DATA_W),
    .DEPTH    (DEPTH),
    .NUM_RD   (NUM_RD),
    .ZERO_REG (1)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .rd_addr  (rd_addr),
    .rd_data  (rd_data),
    .rd_busy  (rd_busy),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .rsv_en   (rsv_en),
    .rsv_addr (rsv_addr),
    .ready    (ready)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, obs, exp, $time);
  endtask

  function automatic logic [DATA_W-1:0] exp_data(input logic [ADDR_W-1:0] a);
    if (!m_ready || a == 0) return '0;
    if (wr_en && wr_addr == a) return wr_data;
    return m_mem[a];
  endfunction

  function automatic logic exp_busy(input logic [ADDR_W-1:0] a);
    if (!m_ready || a == 0) return 1'b0;
    if (wr_en && wr_addr == a) return 1'b0;
    return m_busy[a];
  endfunction

  task automatic model_reset();
    m_ready = 1'b0;
    m_sweep = 0;
    for (int i = 0; i < DEPTH; i++) m_busy[i] = 1'b0;
  endtask

  task automatic model_edge();
    if (!m_ready) begin
      m_sweep++;
      if (m_sweep == DEPTH) begin
        m_ready = 1'b1;
        for (int i = 0; i < DEPTH; i++) m_mem[i] = '0;
      end
    end else begin
      if (wr_en && wr_addr != 0) begin
        m_mem[wr_addr]  = wr_data;
        m_busy[wr_addr] = 1'b0;
      end
      if (rsv_en && rsv_addr != 0) m_busy[rsv_addr] = 1'b1;
    end
  endtask

  // Called just after a falling edge; drives, checks mid-cycle, then advances one edge.
  task automatic cycle(input logic we, input logic [ADDR_W-1:0] wa, input logic [DATA_W-1:0] wd,
                       input logic re, input logic [ADDR_W-1:0] ra,
                       input logic [ADDR_W-1:0] a0, input logic [ADDR_W-1:0] a1);
    wr_en    = we;
    wr_addr  = wa;
    wr_data  = wd;
    rsv_en   = re;
    rsv_addr = ra;
    rd_addr  = {a1, a0};
    #2;
    check("ready",    {63'd0, ready},      {63'd0, m_ready});
    check("rd_data0", {32'd0, rd_data[31:0]},  {32'd0, exp_data(a0)});
    check("rd_data1", {32'd0, rd_data[63:32]}, {32'd0, exp_data(a1)});
    check("rd_busy0", {63'd0, rd_busy[0]}, {63'd0, exp_busy(a0)});
    check("rd_busy1", {63'd0, rd_busy[1]}, {63'd0, exp_busy(a1)});
    @(posedge clk);
    model_edge();
    @(negedge clk);
  endtask

  task automatic async_reset_pulse();
    #2 rst = 1'b1;
    #1;
    check("rst_ready", {63'd0, ready}, 64'd0);
    check("rst_busy",  {62'd0, rd_busy}, 64'd0);
    check("rst_data",  {rd_data}, 64'd0);
    model_reset();
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic sweep_expect(input logic [ADDR_W-1:0] wa, input logic [DATA_W-1:0] wd);
    int n;
    n = 0;
    while (!ready && n < 100) begin
      cycle(1'b1, wa, wd, 1'b1, wa, wa, wa);
      n++;
    end
    check("sweep_len", 64'(n), 64'(DEPTH));
  endtask

  initial begin
    rst = 1'b1;
    wr_en = 1'b0; wr_addr = '0; wr_data = '0;
    rsv_en = 1'b0; rsv_addr = '0; rd_addr = '0;
    model_reset();
    #12;
    check("init_ready", {63'd0, ready}, 64'd0);
    check("init_data",  rd_data, 64'd0);
    @(negedge clk);
    rst = 1'b0;
    sweep_expect(5'd3, 32'h1111);

    // Preload, then reset and try to write during the sweep.
    cycle(1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, 5'd5, 5'd1);
    cycle(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd5, 5'd5);
    async_reset_pulse();
    sweep_expect(5'd5, 32'h1234);
    cycle(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd5, 5'd5);
    check("sweep_clear5", {32'd0, rd_data[31:0]}, 64'd0);

    // Bypass on port 0, port 1 on a neighbour.
    cycle(1'b1, 5'd6, 32'h0BADF00D, 1'b0, 5'd0, 5'd6, 5'd6);
    cycle(1'b1, 5'd7, 32'hA5A5A5A5, 1'b0, 5'd0, 5'd7, 5'd6);
    cycle(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd7, 5'd6);

    // Zero register ignores writes and reservations.
    cycle(1'b1, 5'd0, 32'hFFFFFFFF, 1'b1, 5'd0, 5'd0, 5'd0);
    cycle(1'b0, 5'd0, 32'h0, 1'b1, 5'd0, 5'd0, 5'd0);
    cycle(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd0, 5'd0);

    // Reserve 9, observe busy, then write it back.
    cycle(1'b0, 5'd0, 32'h0, 1'b1, 5'd9, 5'd1, 5'd9);
    cycle(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd1, 5'd9);
    check("busy9", {63'd0, rd_busy[1]}, 64'd1);
    cycle(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd1, 5'd9);
    cycle(1'b1, 5'd9, 32'h55, 1'b0, 5'd0, 5'd1, 5'd9);
    cycle(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd9, 5'd9);

    // Same-cycle reserve and write: reservation wins.
    cycle(1'b1, 5'd12, 32'h77, 1'b1, 5'd12, 5'd12, 5'd12);
    cycle(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd12, 5'd12);
    check("collide_busy", {63'd0, rd_busy[0]}, 64'd1);

    // Random traffic.
    for (int i = 0; i < 400; i++) begin
      cycle(1'($urandom_range(0, 1)), 5'($urandom), $urandom,
            1'($urandom_range(0, 2) == 0), 5'($urandom),
            5'($urandom), 5'($urandom));
    end

    // Reset while register 3 is pending and holds data.
    cycle(1'b1, 5'd3, 32'h99, 1'b0, 5'd0, 5'd3, 5'd3);
    cycle(1'b0, 5'd0, 32'h0, 1'b1, 5'd3, 5'd3, 5'd3);
    cycle(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd3, 5'd3);
    check("pre_rst_busy3", {63'd0, rd_busy[0]}, 64'd1);
    async_reset_pulse();
    sweep_expect(5'd8, 32'h42);
    cycle(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd3, 5'd3);
    check("post_rst_data3", {32'd0, rd_data[31:0]}, 64'd0);
    check("post_rst_busy3", {63'd0, rd_busy[0]}, 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
